// File: rtl/led_mode_sequencer_if.sv
// Button/tick inputs and mode/LED/press-event outputs of the LED mode sequencer.
// The master side drives the button and tick strobes; the sequencer is the slave.
interface led_mode_sequencer_if;
  logic       btn;
  logic       tick_mf;
  logic       tick_lf;
  logic [1:0] state;
  logic       led_a;
  logic       led_b;
  logic       press_short;
  logic       press_long;

  modport master (
    output btn, tick_mf, tick_lf,
    input  state, led_a, led_b, press_short, press_long
  );

  modport slave (
    input  btn, tick_mf, tick_lf,
    output state, led_a, led_b, press_short, press_long
  );
endinterface

// File: rtl/led_mode_sequencer.sv
// Button-driven mode controller: synchronise, debounce, classify short/long presses,
// step a 2-bit mode and drive the two-LED pattern for it.
module led_mode_sequencer #(
  parameter int unsigned DEBOUNCE_N = 4,
  parameter int unsigned LONG_N     = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  led_mode_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {ModeOff, ModeAlt, ModeBlink, ModeSteady} mode_e;
  typedef enum logic [1:0] {ClsIdle, ClsHeld, ClsLongDone} cls_e;

  logic       btn_meta;
  logic       btn_s;
  logic       btn_db;
  logic [3:0] db_cnt;

  cls_e       cls;
  logic [7:0] hold_cnt;
  mode_e      mode;
  mode_e      mode_nxt;
  logic       phase;
  logic       led_a;
  logic       led_b;
  logic       press_short;
  logic       press_long;
  logic       short_ev;
  logic       long_ev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
      btn_db   <= 1'b0;
      db_cnt   <= '0;
    end else begin
      btn_meta <= bus.btn;
      btn_s    <= btn_meta;
      if (bus.tick_mf) begin
        if (btn_s != btn_db) begin
          if (db_cnt == 4'(DEBOUNCE_N - 1)) begin
            btn_db <= ~btn_db;
            db_cnt <= '0;
          end else begin
            db_cnt <= db_cnt + 4'd1;
          end
        end else begin
          db_cnt <= '0;
        end
      end
    end
  end

  // A release coinciding with the final hold tick still counts as a long press.
  always_comb begin
    long_ev  = (cls == ClsHeld) && bus.tick_lf && (hold_cnt == 8'(LONG_N - 1));
    short_ev = (cls == ClsHeld) && !btn_db && !long_ev;
    mode_nxt = mode;
    if (long_ev) begin
      mode_nxt = ModeOff;
    end else if (short_ev) begin
      mode_nxt = mode_e'(mode + 2'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cls         <= ClsIdle;
      hold_cnt    <= '0;
      mode        <= ModeOff;
      phase       <= 1'b0;
      led_a       <= 1'b0;
      led_b       <= 1'b0;
      press_short <= 1'b0;
      press_long  <= 1'b0;
    end else begin
      press_short <= short_ev;
      press_long  <= long_ev;
      mode        <= mode_nxt;

      case (cls)
        ClsIdle: begin
          if (btn_db) begin
            cls      <= ClsHeld;
            hold_cnt <= '0;
          end
        end
        ClsHeld: begin
          if (long_ev) begin
            cls <= ClsLongDone;
          end else if (!btn_db) begin
            cls <= ClsIdle;
          end else if (bus.tick_lf) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        ClsLongDone: begin
          if (!btn_db) begin
            cls <= ClsIdle;
          end
        end
        default: cls <= ClsIdle;
      endcase

      if ((mode_nxt != mode) || (mode == ModeOff)) begin
        phase <= 1'b0;
      end else if (bus.tick_lf) begin
        phase <= ~phase;
      end

      unique case (mode)
        ModeOff: begin
          led_a <= 1'b0;
          led_b <= 1'b0;
        end
        ModeAlt: begin
          led_a <= ~phase;
          led_b <= phase;
        end
        ModeBlink: begin
          led_a <= ~phase;
          led_b <= ~phase;
        end
        ModeSteady: begin
          led_a <= 1'b1;
          led_b <= 1'b1;
        end
      endcase
    end
  end

  assign bus.state       = mode;
  assign bus.led_a       = led_a;
  assign bus.led_b       = led_b;
  assign bus.press_short = press_short;
  assign bus.press_long  = press_long;

endmodule

// File: doc/led_mode_sequencer.md
# led_mode_sequencer

Button-driven Moore controller that sequences the two-LED output stage of the board design. It synchronises and debounces the raw push-button, classifies presses as short or long using the divider's tick outputs, and steps a 2-bit mode register. It generates the `led_a`/`led_b` patterns for the current mode. It replaces the separate button-state and LED-pattern logic under `top`, and consumes `tick_mf`/`tick_lf` from `freq_divider`.

## Interface
- `DEBOUNCE_N`, default 4: consecutive differing `tick_mf` samples needed to accept a new button level (range 2..15).
- `LONG_N`, default 16: `tick_lf` periods of continuous hold that classify a press as long (range 2..255).
- `clk`, input, 1: system clock (100 MHz board clock). All logic is on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `btn`, input, 1: raw, asynchronous push-button level (1 = pressed).
- `tick_mf`, input, 1: one-cycle debounce sample strobe.
- `tick_lf`, input, 1: one-cycle pattern/hold-timing strobe.
- `state`, output, 2: current mode.
  - 00 = OFF, 01 = ALT, 10 = BLINK, 11 = STEADY.
- `led_a`, output, 1: LED A drive, registered.
- `led_b`, output, 1: LED B drive, registered.
- `press_short`, output, 1: one-cycle pulse on each accepted short press.
- `press_long`, output, 1: one-cycle pulse on each accepted long press.

## Operation
- **Synchroniser:** two flops on `btn`, giving `btn_s`. Both flops reset to 0.
- **Debouncer:** `btn_db` (resets to 0) and a counter `db_cnt`.
  - On a `tick_mf` with `btn_s != btn_db`: increment `db_cnt`.
  - On a `tick_mf` with `btn_s == btn_db`: clear `db_cnt`.
  - When the increment would reach `DEBOUNCE_N`: toggle `btn_db` and clear `db_cnt`.
  - `db_cnt` does not change on cycles without `tick_mf`.
- **Press classifier:** states IDLE, HELD, LONG_DONE.
  - IDLE → HELD on the rising edge of `btn_db`; `hold_cnt` is cleared.
  - HELD: each `tick_lf` increments `hold_cnt`. When `hold_cnt` reaches `LONG_N`: pulse `press_long` and go to LONG_DONE.
  - HELD → IDLE on the falling edge of `btn_db` before `LONG_N`: pulse `press_short`.
  - LONG_DONE → IDLE on the falling edge of `btn_db`, with no pulse. `hold_cnt` saturates; at most one event is produced per press.
- **Mode FSM** (Moore, `state` register):
  - `press_short` advances the mode: 00 → 01 → 10 → 11 → 00 (wraps).
  - `press_long` forces 00 from any mode; 00 stays 00.
  - `state` updates on the same edge that asserts `press_*`.
- **Pattern generator:**
  - `phase` toggles on each `tick_lf` when `state != 00`.
  - `phase` clears to 0 on any mode change and while `state == 00`.
  - LED values per mode:
    - OFF: `led_a` = 0, `led_b` = 0.
    - ALT: `led_a` = ~`phase`, `led_b` = `phase`.
    - BLINK: `led_a` = `led_b` = ~`phase`.
    - STEADY: `led_a` = `led_b` = 1.
- **Reset:**
  - All registers go to 0: `state` = 00, `led_a` = `led_b` = 0, `press_short` = `press_long` = 0, classifier = IDLE.
  - A button held through reset release debounces to 1 and counts as a new press start.

## Timing
- `btn` change to `btn_s`: 2 cycles.
- `btn_db` toggles one cycle after the `DEBOUNCE_N`-th qualifying `tick_mf`.
- The classifier edge is seen the cycle after `btn_db` changes.
- `press_short`/`state` update: 1 cycle after the falling edge of `btn_db`.
- `press_long`/`state` update: 1 cycle after the `tick_lf` that brings `hold_cnt` to `LONG_N`.
- `led_a`/`led_b` change 1 cycle after `state` or `phase` changes.
- `tick_mf` and `tick_lf` in the same cycle: both are processed independently.
- A debounced release in the same cycle as the `LONG_N`-th `tick_lf`: treat as long. `press_long` pulses and `press_short` does not.
- Reset asserted mid-press or mid-debounce: immediate clear. No pulse is emitted at or after release of reset for the aborted press.
- Glitches shorter than `DEBOUNCE_N` `tick_mf` periods never change `btn_db`.

## Test plan
- **Reset values:** `rst_n` = 0 with `btn` = 1 and ticks active → `state` = 00, LEDs = 0, no pulses. Release reset, hold the button ≥4 `tick_mf` → classifier enters HELD.
- **Short press and wrap:** 4 short presses (hold 6 `tick_mf`, < 16 `tick_lf`) →
  - one `press_short` pulse each;
  - `state` = 01, 10, 11, 00.
- **Long press:** in mode 10, hold for 20 `tick_lf` →
  - single `press_long` on the 16th `tick_lf`, then `state` = 00;
  - release produces no `press_short`.
- **Debounce rejection:** toggle `btn` every tick for 3 `tick_mf` with `DEBOUNCE_N` = 4 → `btn_db` stays 0, no pulses, `state` unchanged.
- **Patterns:** in ALT, 4 `tick_lf` → (`led_a`, `led_b`) = (1,0), (0,1), (1,0), (0,1), (1,0); then short press → BLINK starts at (1,1), then (0,0).
- **Reset mid-hold:** assert `rst_n` after 10 `tick_lf` of hold in mode 11 →
  - immediate `state` = 00, LEDs = 0;
  - no `press_long` and no `press_short` afterward until a new full press.
